// File: rtl/ifr_pkg.sv
// Shared types and default sizing for the instruction fetch register.
package ifr_pkg;

  localparam int unsigned DEF_BYTE_W    = 8;
  localparam int unsigned DEF_NUM_BYTES = 2;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } ifr_state_e;

endpackage

// File: rtl/ifr_byte_lane.sv
// One byte lane of the instruction register: loadable register with async clear.
module ifr_byte_lane #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_register.sv
// Assembles an instruction from byte lanes by direct lane writes or sequential pushes.
module instruction_fetch_register
  import ifr_pkg::*;
#(
  parameter int unsigned BYTE_W    = DEF_BYTE_W,
  parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
  localparam int unsigned IW       = BYTE_W * NUM_BYTES,
  localparam int unsigned SEL_W    = $clog2(NUM_BYTES),
  localparam int unsigned CNT_W    = $clog2(NUM_BYTES + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [BYTE_W-1:0] I,
  input  logic              Write,
  input  logic [SEL_W-1:0]  Sel,
  input  logic              Push,
  input  logic              Consume,
  input  logic              Flush,
  output logic [IW-1:0]     IROut,
  output logic              Valid,
  output logic              Ready,
  output logic [CNT_W-1:0]  Count
);

  ifr_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     push_lane;
  logic                 push_en;
  logic                 write_en;
  logic [NUM_BYTES-1:0] lane_we;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    push_en   = 1'b0;
    push_lane = '0;
    write_en  = 1'b0;
    if (Flush) begin
      state_d = EMPTY;
      count_d = '0;
    end else if (Write) begin
      // Out-of-range lane index is a no-op, and the write still swallows any push.
      write_en = 32'(Sel) < NUM_BYTES;
    end else if (Push) begin
      unique case (state_q)
        EMPTY: begin
          push_en = 1'b1;
          count_d = CNT_W'(1);
          state_d = FILL;
        end
        FILL: begin
          push_en   = 1'b1;
          push_lane = count_q;
          count_d   = count_q + CNT_W'(1);
          if (count_q == CNT_W'(NUM_BYTES - 1)) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (Consume) begin
            push_en = 1'b1;
            count_d = CNT_W'(1);
            state_d = FILL;
          end
        end
        default: ;
      endcase
    end else if (Consume && (state_q == FULL)) begin
      state_d = EMPTY;
      count_d = '0;
    end
  end

  always_comb begin
    lane_we = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      lane_we[k] = (write_en && (32'(Sel) == 32'(k))) ||
                   (push_en && (32'(push_lane) == 32'(k)));
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    ifr_byte_lane #(
      .WIDTH(BYTE_W)
    ) u_lane (
      .clk(Clock),
      .rst(Reset),
      .we (lane_we[g]),
      .d  (I),
      .q  (IROut[g*BYTE_W +: BYTE_W])
    );
  end

  assign Valid = (state_q == FULL);
  assign Ready = (state_q != FULL);
  assign Count = count_q;

endmodule
